// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and default width.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_add.sv
// One-bit combinational full adder; outputs first to match full_subtract.
module full_add
  import serial_adder_pkg::*;
(
  output logic sum,
  output logic carryOut,
  input  logic a,
  input  logic b,
  input  logic carryIn
);

  assign sum      = a ^ b ^ carryIn;
  assign carryOut = (a & b) | (a & carryIn) | (b & carryIn);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full adder plus a carry flop, LSB first.
// {carryOut,sum} = a + b + carryIn after WIDTH RUN cycles, then a done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_psum_nxt;

  full_add u_fa (
    .sum      (w_s),
    .carryOut (w_c),
    .a        (r_a[0]),
    .b        (r_b[0]),
    .carryIn  (r_carry)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Partial sum fills from the MSB; WIDTH-1 bits of history are enough because
  // the final bit goes straight into the result register.
  if (WIDTH > 1) begin : g_psum
    logic [WIDTH-2:0] r_psum;
    assign w_psum_nxt = {w_s, r_psum};

    // Shift each new sum bit in at the top while running.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                r_psum <= '0;
      else if (r_state == S_RUN) r_psum <= w_psum_nxt[WIDTH-1:1];
    end
  end else begin : g_psum1
    assign w_psum_nxt = w_s;
  end

  // FSM, operand shifters, carry, counter and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      sum      <= '0;
      carryOut <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= carryIn;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            sum      <= w_psum_nxt;
            carryOut <= w_c;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Status decoded straight from the state flop; no input-to-output path.
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule
